// File: rtl/shift_reg_univ.sv
// ---------------------------------------------------------------------------
// shift_reg_univ
//
// Universal shift register: WIDTH D flip-flops sharing one clock, each fed by
// a per-bit multiplexer that selects hold, shift right, shift left or
// parallel load. A small burst controller runs a programmed number of shifts
// after a single start request and reports completion with a one-cycle
// done pulse.
//
// Parameters:
//   WIDTH  number of flip-flop stages (>= 2)
//   CNT_W  width of burst_len and of the internal shift counter
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   en         in   clock enable; 0 freezes q, counter and FSM
//   rot        in   (only with SHIFT_ROTATE_EN) 1 = rotate instead of
//                   taking the serial inputs
//   mode       in   manual op in IDLE: 00 hold, 01 right, 10 left, 11 load
//   ser_in_r   in   bit entering q[WIDTH-1] on a right shift
//   ser_in_l   in   bit entering q[0] on a left shift
//   d_in       in   parallel load data
//   start      in   burst request, sampled in IDLE only
//   burst_dir  in   burst direction: 0 right, 1 left
//   burst_len  in   number of shifts in a burst, captured with start
//   q          out  register contents
//   qn         out  bitwise complement of q
//   ser_out_r  out  q[0]
//   ser_out_l  out  q[WIDTH-1]
//   busy       out  high while a burst is shifting
//   done       out  one-cycle pulse after the last burst shift
//
// Optional feature macro: SHIFT_ROTATE_EN adds the rot input.
// ---------------------------------------------------------------------------
module shift_reg_univ #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef SHIFT_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [1:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] d_in,
    input  logic             start,
    input  logic             burst_dir,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0]       MODE_HOLD  = 2'b00;
    localparam logic [1:0]       MODE_RIGHT = 2'b01;
    localparam logic [1:0]       MODE_LEFT  = 2'b10;
    localparam logic [1:0]       MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qn_r;
    logic [WIDTH-1:0] q_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             busy_r;
    logic             done_r;
    logic             fill_r_s;
    logic             fill_l_s;
    logic [WIDTH-1:0] shr_s;
    logic [WIDTH-1:0] shl_s;

    // Bits entering the vacated end of the word; rotation recirculates the
    // bit falling off the opposite end instead of using the serial inputs.
    always_comb begin
        fill_r_s = ser_in_r;
        fill_l_s = ser_in_l;
`ifdef SHIFT_ROTATE_EN
        if (rot) begin
            fill_r_s = q_r[0];
            fill_l_s = q_r[WIDTH-1];
        end else begin
            fill_r_s = ser_in_r;
            fill_l_s = ser_in_l;
        end
`endif
    end

    // Both shift candidates, shared by manual and burst operation.
    always_comb begin
        shr_s = {fill_r_s, q_r[WIDTH-1:1]};
        shl_s = {q_r[WIDTH-2:0], fill_l_s};
    end

    // Next-state, next-counter and per-bit multiplexer selection.
    always_comb begin
        state_next_s = state_r;
        q_next_s     = q_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    // A start edge never touches q; mode is ignored here.
                    if (burst_len != CNT_ZERO) begin
                        cnt_next_s   = burst_len;
                        state_next_s = ST_BURST;
                    end else begin
                        cnt_next_s   = CNT_ZERO;
                        state_next_s = ST_DONE;
                    end
                end else begin
                    case (mode)
                        MODE_HOLD:  q_next_s = q_r;
                        MODE_RIGHT: q_next_s = shr_s;
                        MODE_LEFT:  q_next_s = shl_s;
                        MODE_LOAD:  q_next_s = d_in;
                        default:    q_next_s = q_r;
                    endcase
                end
            end
            ST_BURST: begin
                if (burst_dir) begin
                    q_next_s = shl_s;
                end else begin
                    q_next_s = shr_s;
                end
                // The counter is always >= 1 in BURST; the guard keeps a
                // corrupted zero from wrapping and leaves the burst at once.
                if (cnt_r > CNT_ONE) begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                    state_next_s = ST_BURST;
                end else begin
                    cnt_next_s   = CNT_ZERO;
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                // Illegal encoding: recover to a quiet IDLE.
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State, data and registered status outputs; en freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            qn_r    <= {WIDTH{1'b1}};
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (en) begin
            state_r <= state_next_s;
            q_r     <= q_next_s;
            qn_r    <= ~q_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s == ST_BURST);
            done_r  <= (state_next_s == ST_DONE);
        end else begin
            state_r <= state_r;
            q_r     <= q_r;
            qn_r    <= qn_r;
            cnt_r   <= cnt_r;
            busy_r  <= busy_r;
            done_r  <= done_r;
        end
    end

    // Serial outputs come straight from the stage flops so a downstream
    // stage sees the bit before the edge that shifts it out.
    assign q         = q_r;
    assign qn        = qn_r;
    assign ser_out_r = q_r[0];
    assign ser_out_l = q_r[WIDTH-1];
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
